// File: rtl/accumulator_processor_n.sv
// Bus-master accumulator. Each batch fetches NUM_OPS operands over the shared
// bus (req/grant/signal handshake), folds them with add/max/min/xor, and
// writes the single result back. Idles between batches under control of en.
module accumulator_processor_n #(
   parameter int DATA_W  = 32,
   parameter int NUM_OPS = 2,
   parameter int SAT     = 0,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              grant,
   input  logic              signal,
   input  logic [DATA_W-1:0] read,
   inout  wire  [1:0]        op,
   output logic [DATA_W-1:0] write,
   output logic              req,
   output logic [5:0]        state,
   output logic              overflow,
   output logic [CNT_W-1:0]  batch_cnt
);

   localparam int               OPC_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam logic [OPC_W-1:0] LAST_OP = OPC_W'(NUM_OPS - 1);

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_MAX = 2'b01;
   localparam logic [1:0] M_MIN = 2'b10;
   localparam logic [1:0] M_XOR = 2'b11;

   localparam logic [1:0] OP_FETCH = 2'b01;
   localparam logic [1:0] OP_SEND  = 2'b10;

   typedef enum logic [5:0] {
      IDLE  = 6'b000001,
      REQ_F = 6'b000010,
      RECV  = 6'b000100,
      ACC   = 6'b001000,
      REQ_S = 6'b010000,
      SEND  = 6'b100000
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   acc_q,   acc_d;
   logic [DATA_W-1:0]   opnd_q,  opnd_d;
   logic [OPC_W-1:0]    cnt_q,   cnt_d;
   logic [1:0]          mode_q,  mode_d;
   logic                ovf_q,   ovf_d;
   logic [CNT_W-1:0]    bcnt_q,  bcnt_d;

   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   fold_val;
   logic                fold_ovf;
   logic                drive_fetch;
   logic                drive_send;

   // One extra bit on the adder exposes the carry for overflow detection.
   assign sum = {1'b0, acc_q} + {1'b0, opnd_q};

   // Reduction of the running accumulator with the newest operand, using
   // the mode latched at the start of the batch.
   always_comb begin
      fold_val = acc_q;
      fold_ovf = 1'b0;
      case (mode_q)
         M_ADD: begin
            fold_val = sum[DATA_W-1:0];
            if (sum[DATA_W]) begin
               fold_ovf = 1'b1;
               if (SAT != 0) fold_val = '1;
            end
         end
         M_MAX:   fold_val = (opnd_q > acc_q) ? opnd_q : acc_q;
         M_MIN:   fold_val = (opnd_q < acc_q) ? opnd_q : acc_q;
         M_XOR:   fold_val = acc_q ^ opnd_q;
         default: fold_val = acc_q;
      endcase
   end

   // Next-state and datapath update. A grant seen while signal is still high
   // belongs to the tail of the previous master's transfer, so it is ignored.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      ovf_d   = ovf_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         IDLE:  if (en) state_d = REQ_F;
         REQ_F: if (grant && !signal) state_d = RECV;
         RECV: begin
            if (signal) begin
               opnd_d  = read;
               state_d = ACC;
            end
         end
         ACC: begin
            if (cnt_q == '0) begin
               // First operand seeds the accumulator and opens a new batch.
               acc_d  = opnd_q;
               mode_d = mode;
               ovf_d  = 1'b0;
            end else begin
               acc_d = fold_val;
               ovf_d = ovf_q | fold_ovf;
            end
            if (cnt_q == LAST_OP) begin
               cnt_d   = '0;
               state_d = REQ_S;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = REQ_F;
            end
         end
         REQ_S: if (grant && !signal) state_d = SEND;
         SEND: begin
            if (signal) begin
               bcnt_d  = bcnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= M_ADD;
         ovf_q   <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         ovf_q   <= ovf_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Bus drive is decoded straight from state so it follows reset with no lag.
   assign drive_fetch = (state_q == RECV);
   assign drive_send  = (state_q == SEND);

   assign op    = (drive_fetch || drive_send) ? (drive_send ? OP_SEND : OP_FETCH) : 2'bzz;
   assign write = drive_send ? acc_q : {DATA_W{1'bz}};

   assign req       = (state_q == REQ_F) || (state_q == RECV) ||
                      (state_q == REQ_S) || (state_q == SEND);
   assign state     = state_q;
   assign overflow  = ovf_q;
   assign batch_cnt = bcnt_q;

endmodule

// File: tb/tb_accumulator_processor_n.sv
// Randomized bench for accumulator_processor_n. Two instances (saturating and
// wrapping) share all inputs; a transaction-level model predicts state, bus
// drive, result, overflow and batch count, checked on every falling edge.
module tb_accumulator_processor_n;

   localparam int DW = 8;
   localparam int N  = 3;
   localparam int MAXV = (1 << DW) - 1;

   localparam logic [5:0] S_IDLE  = 6'b000001;
   localparam logic [5:0] S_REQF  = 6'b000010;
   localparam logic [5:0] S_RECV  = 6'b000100;
   localparam logic [5:0] S_ACC   = 6'b001000;
   localparam logic [5:0] S_REQS  = 6'b010000;
   localparam logic [5:0] S_SEND  = 6'b100000;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [1:0]    mode;
   logic          grant;
   logic          sig;
   logic [DW-1:0] rd;

   wire  [1:0]    op_a, op_b;
   wire  [DW-1:0] wr_a, wr_b;
   logic          req_a, req_b;
   logic [5:0]    st_a, st_b;
   logic          ovf_a, ovf_b;
   logic [15:0]   cnt_a, cnt_b;

   always #5 clk = ~clk;

   accumulator_processor_n #(.DATA_W(DW), .NUM_OPS(N), .SAT(1), .CNT_W(16)) u_sat (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .grant(grant), .signal(sig),
      .read(rd), .op(op_a), .write(wr_a), .req(req_a), .state(st_a),
      .overflow(ovf_a), .batch_cnt(cnt_a));

   accumulator_processor_n #(.DATA_W(DW), .NUM_OPS(N), .SAT(0), .CNT_W(16)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .grant(grant), .signal(sig),
      .read(rd), .op(op_b), .write(wr_b), .req(req_b), .state(st_b),
      .overflow(ovf_b), .batch_cnt(cnt_b));

   int errs   = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // model state
   logic [5:0]    e_st = S_IDLE;
   logic [DW-1:0] e_acc_s = '0, e_acc_w = '0;
   logic          e_ovf_s = 1'b0, e_ovf_w = 1'b0;
   logic [15:0]   e_cnt = '0;
   logic [DW-1:0] cap_s, cap_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] fold(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [1:0] m, input bit sat, output bit ov);
      int s;
      logic [DW-1:0] r;
      ov = 1'b0;
      case (m)
         2'b00: begin
            s = int'(a) + int'(b);
            if (s > MAXV) begin
               ov = 1'b1;
               r  = sat ? DW'(MAXV) : DW'(s - (MAXV + 1));
            end else r = DW'(s);
         end
         2'b01:   r = (a > b) ? a : b;
         2'b10:   r = (a < b) ? a : b;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   task automatic model_acc(input int i, input logic [1:0] m, input logic [DW-1:0] v);
      bit o;
      if (i == 0) begin
         e_acc_s = v; e_acc_w = v; e_ovf_s = 1'b0; e_ovf_w = 1'b0;
      end else begin
         e_acc_s = fold(e_acc_s, v, m, 1'b1, o); e_ovf_s = e_ovf_s | o;
         e_acc_w = fold(e_acc_w, v, m, 1'b0, o); e_ovf_w = e_ovf_w | o;
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("state_sat", st_a, e_st);
         chk("state_wrap", st_b, e_st);
         chk("req_sat", req_a, |(e_st & 6'b110110));
         chk("req_wrap", req_b, |(e_st & 6'b110110));
         if (e_st == S_RECV) begin
            chk("op_fetch_sat", op_a === 2'b01, 1);
            chk("op_fetch_wrap", op_b === 2'b01, 1);
         end else if (e_st == S_SEND) begin
            chk("op_send_sat", op_a === 2'b10, 1);
            chk("op_send_wrap", op_b === 2'b10, 1);
            chk("write_sat", wr_a, e_acc_s);
            chk("write_wrap", wr_b, e_acc_w);
         end else begin
            chk("op_idle_sat", (op_a === 2'b01) || (op_a === 2'b10), 0);
            chk("op_idle_wrap", (op_b === 2'b01) || (op_b === 2'b10), 0);
         end
         chk("ovf_sat", ovf_a, e_ovf_s);
         chk("ovf_wrap", ovf_b, e_ovf_w);
         chk("cnt_sat", cnt_a, e_cnt);
         chk("cnt_wrap", cnt_b, e_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      e_st = S_IDLE;
      en   = 1'b0;
      for (int k = 0; k < n; k++) begin
         grant = 1'($urandom_range(0, 1));
         sig   = 1'($urandom_range(0, 1));
         tick();
      end
      sig = 1'b0;
   endtask

   // Request phase: optional stalls (no grant, or grant during a previous tail)
   task automatic arb(input logic [5:0] st, input bit stall);
      int n;
      n    = stall ? int'($urandom_range(0, 3)) : 0;
      e_st = st;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            grant = 1'b0; sig = 1'($urandom_range(0, 1));
         end else begin
            grant = 1'b1; sig = 1'b1;
         end
         tick();
      end
      grant = 1'b1; sig = 1'b0;
      tick();
   endtask

   task automatic recv(input logic [DW-1:0] v, input bit stall);
      int n;
      n    = stall ? int'($urandom_range(0, 3)) : 0;
      e_st = S_RECV;
      for (int k = 0; k < n; k++) begin
         sig = 1'b0; grant = 1'($urandom_range(0, 1)); rd = DW'($urandom);
         tick();
      end
      sig = 1'b1; rd = v;
      tick();
   endtask

   task automatic send(input bit stall);
      int n;
      n    = stall ? int'($urandom_range(0, 3)) : 0;
      e_st = S_SEND;
      for (int k = 0; k < n; k++) begin
         sig = 1'b0; grant = 1'($urandom_range(0, 1));
         tick();
      end
      cap_s = wr_a; cap_w = wr_b;
      sig = 1'b1;
      tick();
      e_cnt++;
      e_st = S_IDLE;
      sig  = 1'b0;
      en   = 1'b0;
   endtask

   task automatic batch(input logic [1:0] m, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                        input logic [DW-1:0] a2, input bit stall);
      logic [DW-1:0] v [N];
      v[0] = a0; v[1] = a1; v[2] = a2;
      e_st  = S_IDLE;
      en    = 1'b1;
      mode  = m;
      sig   = 1'b0;
      grant = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      en = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i < N; i++) begin
         arb(S_REQF, stall);
         recv(v[i], stall);
         e_st = S_ACC;
         sig  = stall ? 1'($urandom_range(0, 1)) : 1'b0;
         rd   = DW'($urandom);
         tick();
         model_acc(i, m, v[i]);
         if (stall) mode = 2'($urandom_range(0, 3));
      end
      arb(S_REQS, stall);
      send(stall);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; mode = 2'b00; grant = 1'b0; sig = 1'b0; rd = '0;
      tick();
      chk("rst_state", st_a, S_IDLE);
      chk("rst_req", req_a, 0);
      chk("rst_op", (op_a === 2'b01) || (op_a === 2'b10), 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_cnt", cnt_b, 0);
      reset = 1'b0;
      chk_en = 1'b1;
      idle(3);

      // hand-computed pins on the overflow behaviour
      batch(2'b00, 8'd200, 8'd100, 8'd0, 1'b0);
      chk("pin_add_sat", cap_s, 8'd255);
      chk("pin_add_wrap", cap_w, 8'd44);
      chk("pin_ovf_sat", ovf_a, 1);
      chk("pin_ovf_wrap", ovf_b, 1);
      idle(1);
      batch(2'b00, 8'd1, 8'd1, 8'd0, 1'b0);
      chk("pin_small_add", cap_s, 8'd2);
      chk("pin_small_ovf", ovf_a, 0);
      batch(2'b01, 8'd5, 8'hFF, 8'd7, 1'b0);
      chk("pin_max", cap_w, 8'hFF);
      batch(2'b10, 8'd5, 8'hFF, 8'd7, 1'b0);
      chk("pin_min", cap_s, 8'd5);
      batch(2'b10, 8'd5, 8'hFF, 8'd7, 1'b1);
      chk("pin_min_modechg", cap_w, 8'd5);
      chk("pin_cnt", cnt_a, 5);
      idle(4);

      // randomized batches with random stalls and idle gaps
      for (int b = 0; b < 40; b++) begin
         batch(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), DW'($urandom),
               1'($urandom_range(0, 1)));
         idle(int'($urandom_range(0, 2)));
      end

      // asynchronous reset in the middle of a fetch
      e_st = S_IDLE; en = 1'b1; mode = 2'b00; sig = 1'b0; grant = 1'b1;
      tick();
      en = 1'b0;
      arb(S_REQF, 1'b0);
      sig = 1'b0;
      chk_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rstmid_state", st_a, S_IDLE);
      chk("rstmid_req", req_b, 0);
      chk("rstmid_op", (op_a === 2'b01) || (op_a === 2'b10), 0);
      chk("rstmid_cnt", cnt_a, 0);
      chk("rstmid_ovf", ovf_b, 0);
      tick();
      reset = 1'b0; grant = 1'b0;
      e_st = S_IDLE; e_cnt = '0; e_ovf_s = 1'b0; e_ovf_w = 1'b0;
      chk_en = 1'b1;
      idle(2);
      batch(2'b00, 8'd3, 8'd4, 8'd5, 1'b0);
      chk("pin_after_rst", cap_s, 8'd12);
      chk("pin_after_rst_cnt", cnt_b, 1);
      idle(3);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/accumulator_processor_n.md
# accumulator_processor_n

Parametrised bus-master accumulator for the shared-memory accumulator system. Each batch fetches NUM_OPS operands over the shared bus using the request/grant/signal handshake and folds them into an accumulator with a selectable reduction (add, max, min, xor). It then writes the single result back over the bus. Overflow is saturating or wrapping at elaboration time; the block idles between batches under control of `en`.

## Interface
- `DATA_W`, 32: bus/operand/accumulator width.
- `NUM_OPS`, 2: operands per batch, ≥1.
- `SAT`, 0: 1 = saturating add, 0 = wrapping add.
- `CNT_W`, 16: width of `batch_cnt`.

- `clk`  in  1: clock. Asynchronous, active-high `reset` (`reset` input 1).
- `reset`  in  1: asynchronous, active-high.
- `en`  in  1: allows a new batch to start from IDLE.
- `mode`  in  2: reduction, 00 ADD, 01 MAX (unsigned), 10 MIN (unsigned), 11 XOR.
- `grant`  in  1: bus grant from arbiter.
- `signal`  in  1: memory transfer-complete strobe (1 cycle or longer).
- `read`  in  DATA_W: bus read data.
- `op`  inout  2: bus command; 01 FETCH, 10 SEND, else high-Z.
- `write`  out  DATA_W: bus write data; high-Z unless in SEND.
- `req`  out  1: bus request.
- `state`  out  6: one-hot state.
- `overflow`  out  1: carry/saturation occurred in current/last batch (ADD only).
- `batch_cnt`  out  CNT_W: completed batches, wraps.

## Operation
- States, one-hot: IDLE 000001, REQ_F 000010, RECV 000100, ACC 001000, REQ_S 010000, SEND 100000.
- Reset (async, immediate) sets the following:
  - state = IDLE, acc = 0, operand reg = 0, op counter = 0, latched mode = ADD.
  - overflow = 0, batch_cnt = 0, req = 0, op = Z, write = Z.
- `req` = 1 in REQ_F, RECV, REQ_S, SEND, and 0 otherwise (decoded from state, no lag).
- `op`/`write` are decoded from state:
  - FETCH in RECV.
  - SEND with `write` = acc in SEND.
  - Z elsewhere.
- IDLE: `en`=1 → REQ_F; else stay.
- REQ_F: `grant`=1 and `signal`=0 → RECV; otherwise stay. `grant` with `signal`=1 is ignored, because it is the tail of the previous master's transfer.
- RECV: wait for `signal`. On the cycle `signal`=1, capture `read` into the operand reg → ACC. `grant` is not rechecked.
- ACC (1 cycle):
  - If counter = 0:
    - acc ← operand.
    - Latch `mode`.
    - Clear overflow.
  - Else acc ← f(acc, operand) using the latched mode.
  - Counter = NUM_OPS−1 → counter ← 0, go to REQ_S. Else counter++, go to REQ_F.
- ADD arithmetic uses a DATA_W+1 bit sum:
  - On carry, overflow ← 1 (sticky for the batch).
  - SAT=1 → acc ← all ones; SAT=0 → acc ← low DATA_W bits.
- MAX/MIN compare unsigned. XOR is bitwise. These modes never set overflow.
- REQ_S: same rule as REQ_F → SEND.
- SEND: on `signal`=1, batch_cnt++ (wraps) → IDLE.
- NUM_OPS=1: result = the single operand, unmodified.
- `mode` changes mid-batch have no effect. `en` is sampled only in IDLE.

## Timing
- Per operand, minimum 3 cycles: REQ_F, RECV, ACC (grant immediate, `signal` in the first RECV cycle).
- Writeback, minimum 2 cycles: REQ_S, SEND.
- Batch latency from `en` sampled in IDLE to return to IDLE: 1 + 3·NUM_OPS + 2 cycles minimum. Each stall cycle of `grant` or `signal` adds one cycle.
- `req` drops in the cycle after `signal` is sampled, simultaneously with leaving RECV/SEND.
- `overflow` and `batch_cnt` are registered and valid the cycle after the updating edge. `overflow` holds until the next batch's first ACC.

## Test plan
- Sum:
  - Stimulus: NUM_OPS=4, ADD, operands 1,2,3,4, grant tied high, `signal` pulsed on each first RECV/SEND cycle.
  - Response: `write`=10 during SEND, batch_cnt=1, back in IDLE 15 cycles after `en` sampled.
- Overflow, DATA_W=8, ADD, operands 200, 100:
  - SAT=1 → result 255, overflow=1.
  - SAT=0 → result 44, overflow=1.
  - A following batch of 1,1 → result 2, overflow=0.
- MAX/MIN, NUM_OPS=3, operands 5, 0xFFFFFFFF, 7:
  - MAX → 0xFFFFFFFF.
  - MIN → 5.
  - `mode` switched to XOR mid-batch → result unchanged.
- Arbitration:
  - Stimulus: grant withheld 5 cycles in REQ_F, then grant=1 with `signal`=1 for 2 cycles.
  - Response: stays in REQ_F with req=1 until `signal`=0, then RECV; op=Z throughout REQ_F.
- Reset during RECV (op=01): immediately state=000001, req=0, op=Z, write=Z, acc=0; next batch result is correct.
- `en`=0 at batch end: block stays in IDLE with req=0, bus Z. Raising `en` starts a new batch in the next cycle.
